// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
// Shared types and constants for the instruction fetch queue.
//   ifq_state_e : fetch engine state (normal fetch / discarding stale data)
//   PC_INC      : byte stride between sequential instructions
//   ifq_entry_t : one buffered instruction, {pc, instr}, at the default
//                 32-bit width
// ----------------------------------------------------------------------------
package ifq_pkg;

    typedef enum logic {
        IFQ_RUN,
        IFQ_DRAIN
    } ifq_state_e;

    localparam int PC_INC   = 4;
    localparam int IFQ_XLEN = 32;

    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_XLEN-1:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
// Synchronous in-order buffer of fetched instructions.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data at the tail
//   push_data   : entry to store
//   pop         : advance the head (ignored when empty)
//   flush       : discard all entries; wins over push and pop
//   head        : entry at the head (undefined contents when empty)
//   count       : number of buffered entries
//   empty, full : occupancy flags
// ----------------------------------------------------------------------------
import ifq_pkg::*;

module ifq_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ifq_entry_t,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; validity is tracked by count alone,
    // so resetting it would only add reset fan-out for no functional gain.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
// Decoupled instruction prefetcher: generates sequential fetch addresses,
// limits outstanding-plus-buffered instructions to DEPTH, buffers {pc, instr}
// in order, and flushes/refetches on redirect. Stale responses that were in
// flight at a redirect are counted and dropped in the DRAIN state.
// Optional build macro: IFQ_ALIGN_CHECK_EN adds align_err and forces
// redirect_pc[1:0] to zero.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_req/addr/gnt        : fetch request handshake
//   imem_rvalid/rdata        : in-order read responses
//   instr_valid/instr/pc     : queue head toward decode
//   instr_ready              : decode consumes the head
//   redirect, redirect_pc    : taken branch/jump, new fetch PC
//   count                    : buffered entries
//   align_err (optional)     : one-cycle pulse after a misaligned redirect
// ----------------------------------------------------------------------------
import ifq_pkg::*;

module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef IFQ_ALIGN_CHECK_EN
    output logic            align_err,
`endif
    output logic [CW-1:0]   count
);

    // Same layout as ifq_entry_t, sized by XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    ifq_state_e      state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] resp_pc, resp_pc_nxt;
    logic [CW-1:0]   outstanding, outstanding_nxt;
    logic [CW-1:0]   drop_cnt, drop_cnt_nxt;
    logic [XLEN-1:0] redirect_target;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    entry_t          fifo_head;
    entry_t          push_data;

`ifdef IFQ_ALIGN_CHECK_EN
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) align_err <= 1'b0;
        else     align_err <= redirect && (redirect_pc[1:0] != 2'b00);
    end
`else
    assign redirect_target = redirect_pc;
`endif

    // Credit rule: never let in-flight plus buffered exceed the queue size,
    // so every response always has a free slot.
    assign imem_req  = !rst && (state == IFQ_RUN) && !redirect &&
                       (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_gnt;

    assign pop       = instr_valid && instr_ready && !redirect;
    assign push_data = '{pc: resp_pc, instr: imem_rdata};

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        resp_pc_nxt     = resp_pc;
        outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rvalid);
        drop_cnt_nxt    = drop_cnt;
        push            = 1'b0;

        if (redirect) begin
            // Everything still in flight after this edge is stale.
            fetch_pc_nxt = redirect_target;
            resp_pc_nxt  = redirect_target;
            drop_cnt_nxt = outstanding_nxt;
            state_nxt    = (outstanding_nxt != '0) ? IFQ_DRAIN : IFQ_RUN;
        end else begin
            if (accept) begin
                fetch_pc_nxt = fetch_pc + XLEN'(PC_INC);
            end
            if (imem_rvalid) begin
                if (drop_cnt != '0) begin
                    drop_cnt_nxt = drop_cnt - CW'(1);
                end else begin
                    push        = 1'b1;
                    resp_pc_nxt = resp_pc + XLEN'(PC_INC);
                end
            end
            if (state == IFQ_DRAIN && drop_cnt_nxt == '0) begin
                state_nxt = IFQ_RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IFQ_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            resp_pc     <= resp_pc_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
        end
    end

    ifq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? '0 : fifo_head.instr;
    assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

    // The credit rule makes a write into a full queue impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop && !redirect))
        else $error("instr_fetch_queue: queue overflow");

endmodule
